ecdh_host_sequencer: RTL and testbench

//  Host-side initiator for the crypto controller's start/done protocol. Accepts one

---
 rtl/crypto_ctrl_pkg.sv | 17 +
 rtl/seq_timeout_ctr.sv | 18 +
 rtl/ecdh_host_sequencer.sv | 91 +++++++++
 tb/tb_ecdh_host_sequencer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_ctrl_pkg.sv
// crypto_ctrl_pkg: shared command/phase/state types and defaults for the crypto controller host side
package crypto_ctrl_pkg;
  typedef enum logic [1:0] {OP_ECC1, OP_ECC2, OP_DES, OP_FULL} op_t;
  typedef enum logic [1:0] {PH_ECC1, PH_ECC2, PH_DES} phase_t;
  typedef enum logic [2:0] {IDLE, RUN_E1, RUN_E2, RUN_DES, GAP, FIN, ERR} state_t;
  localparam int unsigned TIMEOUT_DEF = 100000;
  localparam int unsigned GAP_DEF = 4;
  function automatic phase_t first_phase(op_t op);
    return op == OP_ECC2 ? PH_ECC2 : op == OP_DES ? PH_DES : PH_ECC1;
  endfunction
  function automatic phase_t next_phase(phase_t p);
    return p == PH_ECC1 ? PH_ECC2 : PH_DES;
  endfunction
  function automatic state_t run_state(phase_t p);
    return p == PH_ECC1 ? RUN_E1 : p == PH_ECC2 ? RUN_E2 : RUN_DES;
  endfunction
endpackage

// File: rtl/seq_timeout_ctr.sv
// seq_timeout_ctr: per-phase watchdog, expires on the LIMIT-th enabled cycle; LIMIT=0 never expires
module seq_timeout_ctr #(
  parameter int unsigned W = 17,
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  assign expire = LIMIT != 0 && en && cnt == W'(LIMIT - 1);
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt <= '0;
    else cnt <= load ? '0 : (en && !expire) ? cnt + W'(1) : cnt;
  end
endmodule

// File: rtl/ecdh_host_sequencer.sv
// ecdh_host_sequencer: host initiator sequencing ECC1/ECC2/DES start-done handshakes with latency and error reporting
module ecdh_host_sequencer
  import crypto_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int unsigned GAP_CYCLES = GAP_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             abort,
  output logic             ecc_start1,
  output logic             ecc_start2,
  output logic             des_start,
  input  logic             ecc1_done,
  input  logic             ecc2_done,
  input  logic             des_done,
  output logic             busy,
  output logic             op_done,
  output logic             err_timeout,
  output logic             err_spurious,
  output logic [1:0]       err_phase,
  output logic [CNT_W-1:0] latency
);
  localparam int unsigned TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state, state_n;
  op_t op_q;
  phase_t phase;
  logic [2:0] starts, starts_n, dones;
  logic [GW-1:0] gap_cnt;
  logic in_run, last, accept, gap_end, done_hit, spur, expire, abort_hit, to_err;
  assign dones = {des_done, ecc2_done, ecc1_done};
  assign {des_start, ecc_start2, ecc_start1} = starts;
  assign in_run = state inside {RUN_E1, RUN_E2, RUN_DES};
  assign last = op_q != OP_FULL || phase == PH_DES;
  assign accept = state == IDLE && cmd_valid;
  assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
  // only the single high start can be matched; any other done is spurious
  assign done_hit = |(dones & starts);
  assign spur = |(dones & ~starts);
  assign abort_hit = abort && state != IDLE;
  assign to_err = in_run && state_n == ERR;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign op_done = state == FIN;
  seq_timeout_ctr #(.W(TW), .LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk(clk), .n_rst(n_rst), .load(~|starts), .en(|starts), .expire(expire)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = cmd_valid ? run_state(first_phase(op_t'(cmd_op))) : IDLE;
      RUN_E1, RUN_E2, RUN_DES: state_n = abort ? IDLE : done_hit ? (last ? FIN : GAP) : expire ? ERR : state;
      GAP: state_n = abort ? IDLE : gap_end ? run_state(next_phase(phase)) : GAP;
      default: state_n = IDLE;
    endcase
    // start rises one cycle after RUN entry and drops on the edge that leaves RUN
    starts_n = (in_run && state_n == state) ? 3'b001 << phase : 3'b000;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      op_q <= OP_ECC1;
      phase <= PH_ECC1;
      starts <= '0;
      gap_cnt <= '0;
      latency <= '0;
      err_timeout <= 1'b0;
      err_spurious <= 1'b0;
      err_phase <= '0;
    end else begin
      state <= state_n;
      starts <= starts_n;
      if (accept) begin
        op_q <= op_t'(cmd_op);
        phase <= first_phase(op_t'(cmd_op));
      end else if (state == GAP && gap_end && !abort) phase <= next_phase(phase);
      gap_cnt <= state == GAP ? gap_cnt + GW'(1) : '0;
      latency <= accept ? '0 : ((in_run || state == GAP) && ~&latency) ? latency + CNT_W'(1) : latency;
      err_timeout <= accept ? 1'b0 : err_timeout | to_err;
      err_spurious <= accept ? 1'b0 : err_spurious | spur;
      if (accept) err_phase <= '0;
      else if (abort_hit) err_phase <= state == GAP ? next_phase(phase) : phase;
      else if (to_err) err_phase <= phase;
    end
  end
endmodule

// File: tb/tb_ecdh_host_sequencer.sv
// tb_ecdh_host_sequencer: directed stimulus with an event scoreboard for the host sequencer
module tb_ecdh_host_sequencer;
  localparam int TO = 16;
  localparam int GAP = 4;
  logic clk = 0, n_rst = 0, cmd_valid = 0, abort = 0;
  logic ecc1_done = 0, ecc2_done = 0, des_done = 0;
  logic [1:0] cmd_op = 0;
  logic cmd_ready, ecc_start1, ecc_start2, des_start, busy, op_done, err_timeout, err_spurious;
  logic [1:0] err_phase;
  logic [31:0] latency;
  logic s_cmd_ready, s_start1, s_start2, s_des_start, s_busy, s_op_done, s_err_timeout, s_err_spurious;
  logic [1:0] s_err_phase;
  logic [2:0] s_latency;
  logic [2:0] starts;
  int n_cmp = 0, n_bad = 0;
  typedef struct {int k; int a; int b;} ev_t;
  ev_t sbq[$];
  assign starts = {des_start, ecc_start2, ecc_start1};

  ecdh_host_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CNT_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .abort(abort), .ecc_start1(ecc_start1), .ecc_start2(ecc_start2), .des_start(des_start),
    .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done), .busy(busy),
    .op_done(op_done), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .err_phase(err_phase), .latency(latency)
  );
  ecdh_host_sequencer #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .CNT_W(3)) u_sat (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(s_cmd_ready),
    .abort(abort), .ecc_start1(s_start1), .ecc_start2(s_start2), .des_start(s_des_start),
    .ecc1_done(ecc1_done), .ecc2_done(ecc2_done), .des_done(des_done), .busy(s_busy),
    .op_done(s_op_done), .err_timeout(s_err_timeout), .err_spurious(s_err_spurious),
    .err_phase(s_err_phase), .latency(s_latency)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // kinds: 0 start pulse (a=start index, b=high cycles), 1 op_done (a=latency), 2 timeout (a=err_phase)
  function automatic void emit(int k, int a, int b);
    ev_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%0d b=%0d, required no event (t=%0t)", k, a, b, $time);
    end else begin
      e = sbq.pop_front();
      chk("event_kind", k, e.k);
      chk("event_a", a, e.a);
      chk("event_b", b, e.b);
      if (k == 1 && e.k == 1) begin
        chk("sat_op_done", s_op_done, 1);
        chk("sat_latency", s_latency, e.a > 7 ? 7 : e.a);
      end
    end
  endfunction

  initial begin
    int w[3];
    int low;
    bit had_fall, prev_any, prev_et, any_h;
    w = '{0, 0, 0};
    low = 0;
    had_fall = 0;
    prev_any = 0;
    prev_et = 0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        w = '{0, 0, 0};
        had_fall = 0;
        prev_any = 0;
        prev_et = 0;
      end else begin
        any_h = |starts;
        chk("one_start_max", $countones(starts) <= 1, 1);
        if (cmd_ready) had_fall = 0;
        else if (any_h && !prev_any && had_fall) begin
          chk("gap_low_cycles_ge", low >= GAP, 1);
          had_fall = 0;
        end else if (!any_h && had_fall) low++;
        for (int i = 0; i < 3; i++) begin
          if (starts[i]) w[i]++;
          else if (w[i] > 0) begin
            emit(0, i, w[i]);
            w[i] = 0;
            had_fall = 1;
            low = 1;
          end
        end
        if (op_done) emit(1, int'(latency), 0);
        if (err_timeout && !prev_et) emit(2, int'(err_phase), 0);
        prev_et = err_timeout;
        prev_any = any_h;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_done(int i, logic v);
    if (i == 0) ecc1_done = v;
    else if (i == 1) ecc2_done = v;
    else des_done = v;
  endtask

  task automatic send(int op);
    int t = 0;
    while (!cmd_ready && t < 64) begin
      cyc(1);
      t++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_op = 2'(op);
    cmd_valid = 1;
    cyc(1);
    cmd_valid = 0;
  endtask

  task automatic wait_start(int i);
    int t = 0;
    while (!starts[i] && t < 64) begin
      cyc(1);
      t++;
    end
    chk("start_seen", starts[i], 1);
  endtask

  // called the cycle the start is first seen high; done is sampled n cycles after the rise
  task automatic pulse(int i, int n);
    cyc(n - 1);
    drive_done(i, 1);
    cyc(1);
    drive_done(i, 0);
  endtask

  initial begin
    #1;
    cyc(3);
    n_rst = 1;
    cyc(1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_starts", starts, 0);
    chk("rst_op_done", op_done, 0);
    chk("rst_errors", {err_timeout, err_spurious, err_phase}, 0);
    chk("rst_latency", latency, 0);

    sbq.push_back('{0, 0, 10});
    sbq.push_back('{1, 11, 0});
    send(0);
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_busy", cmd_ready, 0);
    wait_start(0);
    pulse(0, 10);
    cyc(2);
    chk("t1_idle", cmd_ready, 1);
    chk("t1_latency_hold", latency, 11);

    sbq.push_back('{0, 0, 5});
    sbq.push_back('{0, 1, 5});
    sbq.push_back('{0, 2, 5});
    sbq.push_back('{1, 26, 0});
    send(3);
    for (int p = 0; p < 3; p++) begin
      wait_start(p);
      pulse(p, 5);
    end
    cyc(3);

    sbq.push_back('{0, 2, 16});
    sbq.push_back('{2, 2, 0});
    send(2);
    wait_start(2);
    cyc(20);
    chk("t3_err_timeout", err_timeout, 1);
    chk("t3_err_phase", err_phase, 2);
    chk("t3_idle", cmd_ready, 1);

    sbq.push_back('{0, 0, 5});
    send(3);
    chk("t4_err_timeout_cleared", err_timeout, 0);
    chk("t4_err_phase_cleared", err_phase, 0);
    wait_start(0);
    pulse(0, 5);
    abort = 1;
    cyc(1);
    abort = 0;
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_err_phase", err_phase, 1);
    chk("t4_err_timeout", err_timeout, 0);
    cyc(10);
    chk("t4_no_start", starts, 0);
    chk("t4_still_idle", busy, 0);

    des_done = 1;
    cyc(1);
    des_done = 0;
    chk("t5_spurious_idle", err_spurious, 1);
    sbq.push_back('{0, 0, 8});
    sbq.push_back('{1, 9, 0});
    send(0);
    chk("t5_spurious_cleared", err_spurious, 0);
    wait_start(0);
    cyc(2);
    ecc2_done = 1;
    cyc(1);
    ecc2_done = 0;
    chk("t5_spurious_run", err_spurious, 1);
    chk("t5_still_running", ecc_start1, 1);
    cyc(4);
    ecc1_done = 1;
    cyc(1);
    ecc1_done = 0;
    cyc(3);

    send(1);
    wait_start(1);
    cyc(3);
    #2;
    n_rst = 0;
    #1;
    chk("t6_starts_async", starts, 0);
    chk("t6_ready_in_reset", cmd_ready, 1);
    #9;
    n_rst = 1;
    cyc(1);
    chk("t6_ready_after", cmd_ready, 1);
    chk("t6_busy_after", busy, 0);
    chk("t6_start2_after", ecc_start2, 0);

    sbq.push_back('{0, 0, 16});
    sbq.push_back('{1, 17, 0});
    send(0);
    wait_start(0);
    pulse(0, 16);
    cyc(3);
    chk("t6_done_wins_timeout", err_timeout, 0);
    chk("t6_idle", cmd_ready, 1);

    cyc(5);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1);
  end
endmodule
